// File: rtl/cam_ycbcr2rgb.sv
// ---------------------------------------------------------------------------
// cam_ycbcr2rgb
//
// Streaming full-range BT.601 YCbCr 4:4:4 -> RGB converter, PPC pixels per
// clock, 3-stage pipeline with valid/ready on both sides.
//
//   stage 1 : remove chroma offset   (cb_d, cr_d signed, DATA_WIDTH+1 bits)
//   stage 2 : fixed-point products   (8 fractional bits), y scaled by 256
//   stage 3 : sum, round, shift, clamp -> registered outputs
//
// Ports
//   clk        pipeline clock
//   rst        synchronous, active-high reset
//   in_valid   input beat valid
//   in_ready   pipeline advances this cycle (combinational from out_*)
//   in_y       luma, unsigned, PPC lanes of DATA_WIDTH bits
//   in_cb      blue chroma, offset-binary
//   in_cr      red chroma, offset-binary
//   in_last    end-of-line marker, carried with its beat
//   out_valid  output beat valid
//   out_ready  downstream accepts the beat
//   out_red    clamped red,   PPC lanes
//   out_green  clamped green, PPC lanes
//   out_blue   clamped blue,  PPC lanes
//   out_last   in_last of the beat currently presented
//
// Lane i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]. Intended range
// of DATA_WIDTH is 8..12.
// ---------------------------------------------------------------------------
module cam_ycbcr2rgb #(
  parameter int DATA_WIDTH = 8,
  parameter int PPC        = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PPC*DATA_WIDTH-1:0] in_y,
  input  logic [PPC*DATA_WIDTH-1:0] in_cb,
  input  logic [PPC*DATA_WIDTH-1:0] in_cr,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PPC*DATA_WIDTH-1:0] out_red,
  output logic [PPC*DATA_WIDTH-1:0] out_green,
  output logic [PPC*DATA_WIDTH-1:0] out_blue,
  output logic                      out_last
);

  localparam int DW = DATA_WIDTH;
  // chroma difference width
  localparam int CW = DATA_WIDTH + 1;
  // product / sum width; largest term is 454*2^(DW-1) + 255*256 + 128
  localparam int PW = DATA_WIDTH + 12;

  localparam logic [DW-1:0]        MID    = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [PW-1:0] K_R    = PW'(32'sd359);
  localparam logic signed [PW-1:0] K_G_CB = PW'(32'sd88);
  localparam logic signed [PW-1:0] K_G_CR = PW'(32'sd183);
  localparam logic signed [PW-1:0] K_B    = PW'(32'sd454);
  localparam logic signed [PW-1:0] RND    = PW'(32'sd128);
  localparam logic signed [PW-1:0] MAXV   = PW'((32'sd1 <<< DW) - 32'sd1);

  // Saturate a signed integer-domain result into the unsigned output range.
  function automatic logic [DW-1:0] clamp_pix(input logic signed [PW-1:0] v);
    logic [DW-1:0] res;
    if (v[PW-1]) begin
      res = '0;
    end else if (v > MAXV) begin
      res = '1;
    end else begin
      res = v[DW-1:0];
    end
    return res;
  endfunction

  // Pipeline advance enable shared by every stage.
  logic en_s;

  // Stage 1 registers
  logic                 v1_r;
  logic                 last1_r;
  logic [DW-1:0]        y1_r   [PPC];
  logic signed [CW-1:0] cbd1_r [PPC];
  logic signed [CW-1:0] crd1_r [PPC];

  // Stage 2 registers
  logic                 v2_r;
  logic                 last2_r;
  logic signed [PW-1:0] ys2_r   [PPC];
  logic signed [PW-1:0] roff2_r [PPC];
  logic signed [PW-1:0] goff2_r [PPC];
  logic signed [PW-1:0] boff2_r [PPC];

  // Combinational per-lane intermediates
  logic signed [CW-1:0] cbd_s  [PPC];
  logic signed [CW-1:0] crd_s  [PPC];
  logic signed [PW-1:0] cbx_s  [PPC];
  logic signed [PW-1:0] crx_s  [PPC];
  logic signed [PW-1:0] ys_s   [PPC];
  logic signed [PW-1:0] roff_s [PPC];
  logic signed [PW-1:0] goff_s [PPC];
  logic signed [PW-1:0] boff_s [PPC];
  logic signed [PW-1:0] rsum_s [PPC];
  logic signed [PW-1:0] gsum_s [PPC];
  logic signed [PW-1:0] bsum_s [PPC];
  logic signed [PW-1:0] rsh_s  [PPC];
  logic signed [PW-1:0] gsh_s  [PPC];
  logic signed [PW-1:0] bsh_s  [PPC];

  // A stall (valid output not taken) freezes the whole pipe, bubbles included.
  assign en_s     = !out_valid || out_ready;
  assign in_ready = en_s;

  // Stage 1 datapath: strip the offset-binary midpoint from both chroma lanes.
  always_comb begin
    for (int i = 0; i < PPC; i++) begin
      cbd_s[i] = $signed({1'b0, in_cb[i*DW +: DW]}) - $signed({1'b0, MID});
      crd_s[i] = $signed({1'b0, in_cr[i*DW +: DW]}) - $signed({1'b0, MID});
    end
  end

  // Stage 2 datapath: fixed-point coefficient products, luma scaled to match.
  always_comb begin
    for (int i = 0; i < PPC; i++) begin
      cbx_s[i]  = PW'(cbd1_r[i]);
      crx_s[i]  = PW'(crd1_r[i]);
      ys_s[i]   = $signed(PW'({y1_r[i], 8'h00}));
      roff_s[i] = crx_s[i] * K_R;
      goff_s[i] = (cbx_s[i] * K_G_CB) + (crx_s[i] * K_G_CR);
      boff_s[i] = cbx_s[i] * K_B;
    end
  end

  // Stage 3 datapath: add, round to nearest, drop the 8 fractional bits.
  always_comb begin
    for (int i = 0; i < PPC; i++) begin
      rsum_s[i] = ys2_r[i] + roff2_r[i] + RND;
      gsum_s[i] = ys2_r[i] - goff2_r[i] + RND;
      bsum_s[i] = ys2_r[i] + boff2_r[i] + RND;
      rsh_s[i]  = rsum_s[i] >>> 4'd8;
      gsh_s[i]  = gsum_s[i] >>> 4'd8;
      bsh_s[i]  = bsum_s[i] >>> 4'd8;
    end
  end

  // Control path and output registers: valids, last and clamped pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_red   <= '0;
      out_green <= '0;
      out_blue  <= '0;
    end else if (en_s) begin
      v1_r      <= in_valid;
      v2_r      <= v1_r;
      out_valid <= v2_r;
      out_last  <= last2_r;
      for (int i = 0; i < PPC; i++) begin
        out_red[i*DW +: DW]   <= clamp_pix(rsh_s[i]);
        out_green[i*DW +: DW] <= clamp_pix(gsh_s[i]);
        out_blue[i*DW +: DW]  <= clamp_pix(bsh_s[i]);
      end
    end
  end

  // Stage 1 and 2 data registers; contents are qualified by the valid bits,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (en_s) begin
      last1_r <= in_last;
      last2_r <= last1_r;
      for (int i = 0; i < PPC; i++) begin
        y1_r[i]    <= in_y[i*DW +: DW];
        cbd1_r[i]  <= cbd_s[i];
        crd1_r[i]  <= crd_s[i];
        ys2_r[i]   <= ys_s[i];
        roff2_r[i] <= roff_s[i];
        goff2_r[i] <= goff_s[i];
        boff2_r[i] <= boff_s[i];
      end
    end
  end

endmodule

// File: tb/tb_cam_ycbcr2rgb.sv
// ---------------------------------------------------------------------------
// tb_cam_ycbcr2rgb
//
// Self-checking bench for cam_ycbcr2rgb (DATA_WIDTH=8, PPC=2): directed colour
// and clamp beats with latency checks, a randomized backpressure stream
// scored against a behavioural integer model, and a mid-stream reset flush.
// ---------------------------------------------------------------------------
module tb_cam_ycbcr2rgb;

  localparam int DW  = 8;
  localparam int PPC = 2;
  localparam int LW  = PPC * DW;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] in_y;
  logic [LW-1:0] in_cb;
  logic [LW-1:0] in_cr;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_red;
  logic [LW-1:0] out_green;
  logic [LW-1:0] out_blue;
  logic          out_last;

  int n_vec = 0;
  int n_bad = 0;

  cam_ycbcr2rgb #(.DATA_WIDTH(DW), .PPC(PPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .in_cb     (in_cb),
    .in_cr     (in_cr),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_red   (out_red),
    .out_green (out_green),
    .out_blue  (out_blue),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something outside the bounded loops hangs.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: full-range BT.601 with 8 fractional bits, rounded.
  function automatic int clamp8(input int v);
    if (v < 0) return 0;
    else if (v > 255) return 255;
    else return v;
  endfunction

  function automatic logic [23:0] ref_pix(input int y, input int cb, input int cr);
    int cd;
    int rd;
    int r;
    int g;
    int b;
    cd = cb - 128;
    rd = cr - 128;
    r  = (y * 256 + 359 * rd + 128) >>> 8;
    g  = (y * 256 - (88 * cd + 183 * rd) + 128) >>> 8;
    b  = (y * 256 + 454 * cd + 128) >>> 8;
    return {8'(clamp8(r)), 8'(clamp8(g)), 8'(clamp8(b))};
  endfunction

  // Expected beat packed as {last, red, green, blue}.
  function automatic logic [3*LW:0] ref_beat(input logic [LW-1:0] y, input logic [LW-1:0] cb,
                                             input logic [LW-1:0] cr, input logic last);
    logic [LW-1:0] r;
    logic [LW-1:0] g;
    logic [LW-1:0] b;
    logic [23:0]   p;
    for (int l = 0; l < PPC; l++) begin
      p = ref_pix(int'(y[l*DW +: DW]), int'(cb[l*DW +: DW]), int'(cr[l*DW +: DW]));
      r[l*DW +: DW] = p[23:16];
      g[l*DW +: DW] = p[15:8];
      b[l*DW +: DW] = p[7:0];
    end
    return {last, r, g, b};
  endfunction

  function automatic logic [3*LW:0] obs_beat();
    return {out_last, out_red, out_green, out_blue};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat through an empty pipe with out_ready high; checks
  // latency and the exact pixel values.
  task automatic run_one(input string tag, input logic [LW-1:0] y, input logic [LW-1:0] cb,
                         input logic [LW-1:0] cr, input logic [3*LW:0] exp);
    int  n;
    logic got;
    n         = 0;
    got       = 1'b0;
    in_y      = y;
    in_cb     = cb;
    in_cr     = cr;
    in_last   = exp[3*LW];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (n < 10 && !got) begin
      tick();
      n++;
      in_valid = 1'b0;
      if (out_valid) got = 1'b1;
    end
    check_val({tag, "_latency"}, n, 3);
    check_val(tag, obs_beat(), exp);
    tick();
  endtask

  logic [3*LW:0] q[$];
  int            sent;
  int            recv;
  int            cyc;
  int            ghost;
  logic          accepted;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_y      = '0;
    in_cb     = '0;
    in_cr     = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    check_val("rst_outputs", {out_valid, out_last, out_red, out_green, out_blue}, '0);
    rst = 1'b0;
    tick();
    check_val("rst_in_ready", {out_valid, in_ready}, 2'b01);

    // Directed colours and clamps (lane1, lane0)
    run_one("grey", {8'd128, 8'd128}, {8'd128, 8'd128}, {8'd128, 8'd128},
            {1'b0, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128});
    run_one("red", {8'd76, 8'd76}, {8'd85, 8'd85}, {8'd255, 8'd255},
            {1'b1, 8'd254, 8'd254, 8'd0, 8'd0, 8'd0, 8'd0});
    run_one("white", {8'd255, 8'd255}, {8'd128, 8'd128}, {8'd128, 8'd128},
            {1'b0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255});
    run_one("clamp_hi", {8'd255, 8'd255}, {8'd128, 8'd128}, {8'd255, 8'd255},
            {1'b0, 8'd255, 8'd255, 8'd164, 8'd164, 8'd255, 8'd255});
    run_one("clamp_lo_r", {8'd0, 8'd0}, {8'd128, 8'd128}, {8'd0, 8'd0},
            {1'b1, 8'd0, 8'd0, 8'd92, 8'd92, 8'd0, 8'd0});
    run_one("clamp_lo_b", {8'd0, 8'd0}, {8'd0, 8'd0}, {8'd128, 8'd128},
            {1'b0, 8'd0, 8'd0, 8'd44, 8'd44, 8'd0, 8'd0});
    run_one("lanes", {8'd76, 8'd128}, {8'd85, 8'd128}, {8'd255, 8'd128},
            {1'b0, 8'd254, 8'd128, 8'd0, 8'd128, 8'd0, 8'd128});

    // Randomized stream with backpressure and input gaps
    sent     = 0;
    recv     = 0;
    cyc      = 0;
    in_valid = 1'b0;
    while ((sent < 20 || q.size() > 0) && cyc < 2000) begin
      if (!in_valid && sent < 20 && $urandom_range(0, 2) != 0) begin
        in_y     = {8'(sent * 12 + 3), 8'(sent * 12)};
        in_cb    = LW'($urandom);
        in_cr    = LW'($urandom);
        in_last  = (sent == 19);
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(0, 1));
      accepted  = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        if (q.size() == 0) begin
          check_val("extra_beat", out_valid, 1'b0);
        end else begin
          check_val(out_ready ? "beat" : "stall_hold", obs_beat(), q[0]);
          if (out_ready) begin
            void'(q.pop_front());
            recv++;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_beat(in_y, in_cb, in_cr, in_last));
        sent++;
        accepted = 1'b1;
      end
      tick();
      if (accepted) in_valid = 1'b0;
      cyc++;
    end
    check_val("stream_count", recv, 20);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    // Reset with three beats in flight and the output stalled
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_y     = {8'd76, 8'd76};
      in_cb    = {8'd85, 8'd85};
      in_cr    = {8'd255, 8'd255};
      in_last  = 1'b1;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check_val("inflight_full", {out_valid, in_ready}, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rst_flush", {out_valid, out_last}, 2'b00);
    out_ready = 1'b1;
    ghost     = 0;
    repeat (6) begin
      tick();
      if (out_valid) ghost++;
    end
    check_val("ghost_beats", ghost, 0);
    run_one("post_rst", {8'd128, 8'd128}, {8'd128, 8'd128}, {8'd128, 8'd128},
            {1'b0, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cam_ycbcr2rgb.md
# cam_ycbcr2rgb

Streaming full-range BT.601 YCbCr 4:4:4 to RGB converter for the camera/display pixel path. It is the inverse of the luma-extraction stage: Y, Cb and Cr for PPC pixels per clock come in, and clamped R, G and B words go out. The datapath is a 3-stage pipeline with valid/ready handshakes on both sides. A frame sideband bit is carried through aligned with its pixel data.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per colour component; supported range 8..12.
- PPC, 2, pixels per clock; lane i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].

Ports:
- clk  in  1  pipeline clock; one clock only.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_y  in  PPC*DATA_WIDTH  luma, unsigned.
- in_cb  in  PPC*DATA_WIDTH  blue chroma, offset-binary (midpoint 2^(DATA_WIDTH-1)).
- in_cr  in  PPC*DATA_WIDTH  red chroma, offset-binary.
- in_last  in  1  end-of-line marker, passed through unchanged.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_red / out_green / out_blue  out  PPC*DATA_WIDTH  each output component, unsigned, clamped.
- out_last  out  1  in_last delayed to match its beat.

## Operation
- The clock is single and the reset is synchronous active-high; both are fixed.
- Pipeline advance enable: en = !out_valid || out_ready. All stages advance together on en.
- in_ready = en. This is combinational from out_ready and out_valid. A stall freezes every stage, including bubbles.
- A beat is accepted when in_valid && in_ready. The valid bit enters stage-1 valid on en.
- Stage 1 (per lane): cb_d = Cb - 2^(DATA_WIDTH-1) and cr_d = Cr - 2^(DATA_WIDTH-1), both signed, DATA_WIDTH+1 bits. Y and last are registered alongside.
- Stage 2 (per lane), signed products with 8 fractional bits:
  - r_off = 359*cr_d
  - g_off = 88*cb_d + 183*cr_d
  - b_off = 454*cb_d
  - Width is DATA_WIDTH+12 signed.
  - y_s = Y<<8 is registered.
- Stage 3 (per lane):
  - R = (y_s + r_off + 128) >>> 8
  - G = (y_s - g_off + 128) >>> 8
  - B = (y_s + b_off + 128) >>> 8
  - Each result is clamped: negative becomes 0, and a value above 2^DATA_WIDTH-1 becomes 2^DATA_WIDTH-1. The result is then registered to the outputs.
- Lanes are independent and have no cross-lane arithmetic.
- out_last always equals the in_last of the beat currently presented.
- While out_valid && !out_ready, all outputs hold stable. Data, valid and last do not change until the beat is accepted.
- Reset:
  - All stage valid bits go to 0, out_valid = 0, out_last = 0.
  - out_red, out_green and out_blue go to 0.
  - Internal data registers need no reset.
  - in_ready is 1 in the cycle after reset deasserts, because out_valid = 0.
- Reset asserted mid-stream discards every in-flight beat. No partial beat is emitted after reset.

## Timing
- Latency: 3 clk from acceptance to out_valid when out_ready is held high.
- Throughput: 1 beat/clk sustained with out_ready = 1.
- The pipeline holds at most 3 beats. On out_ready deassertion, in_ready drops in the same cycle only if out_valid = 1.
- out_ready may toggle every cycle. No beat may be lost or duplicated.
- in_valid may drop between beats. Bubbles propagate as valid = 0 stages.

## Test plan
- Reset then neutral grey: Y=128, Cb=128, Cr=128 on all lanes (DATA_WIDTH=8) -> R=G=B=128, out_valid exactly 3 clk after acceptance, and all outputs 0 during reset.
- Primary red: Y=76, Cb=85, Cr=255 -> R=254, G=0, B=0. Pure white: Y=255, Cb=Cr=128 -> 255,255,255.
- Clamp:
  - Y=255, Cb=128, Cr=255 -> R=255 (upper clamp).
  - Y=0, Cb=128, Cr=0 -> R=0 (lower clamp).
  - Y=0, Cb=0, Cr=128 -> B=0.
- Backpressure: a stream of 20 incrementing-Y beats with random out_ready (~50%) and random in_valid gaps -> output sequence equals the reference-model sequence with no drops or duplicates, outputs are stable while stalled, and out_last matches on the 20th beat.
- Lane independence, PPC=2: lane0 neutral grey and lane1 primary red in the same beat -> lane0 (128,128,128) and lane1 (254,0,0) in the same output beat.
- Reset mid-operation: assert rst for 1 clk with 3 beats in flight and out_ready=0 -> out_valid=0 the next cycle, none of the 3 beats ever appears, and the next accepted beat emerges after 3 clk.
